// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku design: timer state encoding,
// BCD digit type, mm:ss record and active-high 7-segment glyphs.
package sudoku_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  // Segment order {g,f,e,d,c,b,a}, lit = 1
  localparam logic [SEG_W-1:0] SEG_GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_GLYPH_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_GLYPH_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK   = 7'h00;

  // Digit-wise BCD increment of mm:ss with ripple carries; minutes wrap at 99.
  function automatic mmss_t mmss_inc(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_ones == bcd_t'(9)) begin
      r.sec_ones = '0;
      if (t.sec_tens == bcd_t'(5)) begin
        r.sec_tens = '0;
        if (t.min_ones == bcd_t'(9)) begin
          r.min_ones = '0;
          r.min_tens = (t.min_tens == bcd_t'(9)) ? '0 : bcd_t'(t.min_tens + bcd_t'(1));
        end else begin
          r.min_ones = bcd_t'(t.min_ones + bcd_t'(1));
        end
      end else begin
        r.sec_tens = bcd_t'(t.sec_tens + bcd_t'(1));
      end
    end else begin
      r.sec_ones = bcd_t'(t.sec_ones + bcd_t'(1));
    end
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] bcd_glyph(input bcd_t d);
    logic [SEG_W-1:0] g;
    case (d)
      bcd_t'(0): g = SEG_GLYPH_0;
      bcd_t'(1): g = SEG_GLYPH_1;
      bcd_t'(2): g = SEG_GLYPH_2;
      bcd_t'(3): g = SEG_GLYPH_3;
      bcd_t'(4): g = SEG_GLYPH_4;
      bcd_t'(5): g = SEG_GLYPH_5;
      bcd_t'(6): g = SEG_GLYPH_6;
      bcd_t'(7): g = SEG_GLYPH_7;
      bcd_t'(8): g = SEG_GLYPH_8;
      bcd_t'(9): g = SEG_GLYPH_9;
      default:   g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decode {g,f,e,d,c,b,a}; non-BCD codes blank.
module bcd_to_seg7
  import sudoku_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  bcd_t             bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = bcd_glyph(bcd);
    if (ACTIVE_LOW) seg_c = ~seg_c;
  end

endmodule

// File: rtl/game_timer.sv
// BCD mm:ss game clock with start/pause/clear and a freeze at LIMIT_MIN:00.
// Optional registered 7-segment outputs when GAME_TIMER_SEG7_EN is defined.
module game_timer
  import sudoku_pkg::*;
#(
  parameter int unsigned LIMIT_MIN      = 30,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic clk_1Hz,
  input  logic start,
  input  logic pause,
  input  logic clear,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic running,
  output logic time_up
`ifdef GAME_TIMER_SEG7_EN
  ,
  output logic [SEG_W-1:0] hex3,
  output logic [SEG_W-1:0] hex2,
  output logic [SEG_W-1:0] hex1,
  output logic [SEG_W-1:0] hex0
`endif
);

  if (LIMIT_MIN < 1 || LIMIT_MIN > 99 || SEG_ACTIVE_LOW > 1) begin : g_bad_param
    $error("game_timer: LIMIT_MIN must be 1..99 and SEG_ACTIVE_LOW 0 or 1");
  end

  localparam mmss_t LIMIT_VAL = mmss_t'({bcd_t'(LIMIT_MIN / 10), bcd_t'(LIMIT_MIN % 10), 8'h00});

  timer_state_t state;
  mmss_t        count;
  mmss_t        count_inc_c;

  assign count_inc_c = mmss_inc(count);

  // Control priority: clear, then pause, then start, then the 1 Hz strobe.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      running <= 1'b0;
      time_up <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      count   <= '0;
      running <= 1'b0;
      time_up <= 1'b0;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (!pause && start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (clk_1Hz) begin
            count <= count_inc_c;
            if (count_inc_c == LIMIT_VAL) begin
              state   <= EXPIRED;
              running <= 1'b0;
              time_up <= 1'b1;
            end
          end
        end
        EXPIRED: begin
          state <= EXPIRED;
        end
        default: begin
          state   <= IDLE;
          count   <= '0;
          running <= 1'b0;
          time_up <= 1'b0;
        end
      endcase
    end
  end

  assign min_tens = count.min_tens;
  assign min_ones = count.min_ones;
  assign sec_tens = count.sec_tens;
  assign sec_ones = count.sec_ones;

`ifdef GAME_TIMER_SEG7_EN
  localparam bit              SEG_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_ZERO = SEG_LOW ? ~SEG_GLYPH_0 : SEG_GLYPH_0;

  logic [SEG_W-1:0] seg3_c, seg2_c, seg1_c, seg0_c;

  bcd_to_seg7 #(.ACTIVE_LOW(SEG_LOW)) u_seg3 (.bcd(count.min_tens), .seg_c(seg3_c));
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_LOW)) u_seg2 (.bcd(count.min_ones), .seg_c(seg2_c));
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_LOW)) u_seg1 (.bcd(count.sec_tens), .seg_c(seg1_c));
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_LOW)) u_seg0 (.bcd(count.sec_ones), .seg_c(seg0_c));

  // Display registers trail the BCD registers by one cycle.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      hex3 <= SEG_ZERO;
      hex2 <= SEG_ZERO;
      hex1 <= SEG_ZERO;
      hex0 <= SEG_ZERO;
    end else begin
      hex3 <= seg3_c;
      hex2 <= seg2_c;
      hex1 <= seg1_c;
      hex0 <= seg0_c;
    end
  end
`endif

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: two instances (LIMIT_MIN 30 and 1) on shared stimulus.
module tb_game_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_1hz = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic clear = 1'b0;

  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic       a_run, a_up, b_run, b_up;
`ifdef GAME_TIMER_SEG7_EN
  logic [6:0] a_hex3, a_hex2, a_hex1, a_hex0, b_hex3, b_hex2, b_hex1, b_hex0;
`endif

  always #5 clk = ~clk;

  game_timer #(.LIMIT_MIN(30), .SEG_ACTIVE_LOW(1)) dut (
    .clk_50MHz(clk), .rst_n(rst_n), .clk_1Hz(clk_1hz),
    .start(start), .pause(pause), .clear(clear),
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .running(a_run), .time_up(a_up)
`ifdef GAME_TIMER_SEG7_EN
    , .hex3(a_hex3), .hex2(a_hex2), .hex1(a_hex1), .hex0(a_hex0)
`endif
  );

  game_timer #(.LIMIT_MIN(1), .SEG_ACTIVE_LOW(1)) dut_lim (
    .clk_50MHz(clk), .rst_n(rst_n), .clk_1Hz(clk_1hz),
    .start(start), .pause(pause), .clear(clear),
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .running(b_run), .time_up(b_up)
`ifdef GAME_TIMER_SEG7_EN
    , .hex3(b_hex3), .hex2(b_hex2), .hex1(b_hex1), .hex0(b_hex0)
`endif
  );

  typedef struct {
    string      name;
    bit         lim;
    logic [15:0] tm;
    logic       run;
    logic       up;
  } exp_t;

  typedef struct {
    logic s, p, c, t;
    int   secs;
    logic run;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] bcd_of(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic expect_out(input string name, input bit lim, input int secs,
                            input logic run, input logic up);
    exp_t e;
    e.name = name; e.lim = lim; e.tm = bcd_of(secs); e.run = run; e.up = up;
    sb.push_back(e);
  endtask

  task automatic expect_both(input string name, input int secs, input logic run);
    expect_out(name, 1'b0, secs, run, 1'b0);
    expect_out(name, 1'b1, secs, run, 1'b0);
  endtask

  task automatic compare_all();
    exp_t e;
    logic [15:0] tm;
    logic run, up;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tm  = e.lim ? {b_mt, b_mo, b_st, b_so} : {a_mt, a_mo, a_st, a_so};
      run = e.lim ? b_run : a_run;
      up  = e.lim ? b_up : a_up;
      checks++;
      if (tm !== e.tm || run !== e.run || up !== e.up) begin
        errors++;
        $display("FAIL %s [%s]: got %h run=%b up=%b, expected %h run=%b up=%b",
                 e.name, e.lim ? "lim1" : "lim30", tm, run, up, e.tm, e.run, e.up);
      end
    end
  endtask

  // Drive inputs from a negedge, compare just after the next posedge, return at negedge.
  task automatic cycle(input logic s, input logic p, input logic c, input logic t);
    start = s; pause = p; clear = c; clk_1hz = t;
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    start = 1'b0; pause = 1'b0; clear = 1'b0; clk_1hz = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      clk_1hz = 1'b1;
      @(negedge clk);
      clk_1hz = 1'b0;
      @(negedge clk);
    end
  endtask

`ifdef GAME_TIMER_SEG7_EN
  task automatic check_hex(input string name, input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0);
    checks++;
    if ({a_hex3, a_hex2, a_hex1, a_hex0} !== {h3, h2, h1, h0}) begin
      errors++;
      $display("FAIL %s: got %h %h %h %h, expected %h %h %h %h", name,
               a_hex3, a_hex2, a_hex1, a_hex0, h3, h2, h1, h0);
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{s:0, p:0, c:0, t:1, secs:0, run:0}; // strobe in IDLE ignored
    vecs[1]  = '{s:0, p:1, c:0, t:0, secs:0, run:0}; // pause in IDLE no effect
    vecs[2]  = '{s:1, p:0, c:0, t:1, secs:0, run:1}; // start: same-cycle strobe not counted
    vecs[3]  = '{s:0, p:0, c:0, t:1, secs:1, run:1};
    vecs[4]  = '{s:0, p:0, c:0, t:0, secs:1, run:1};
    vecs[5]  = '{s:0, p:1, c:0, t:1, secs:1, run:0}; // pause drops strobe
    vecs[6]  = '{s:0, p:0, c:0, t:1, secs:1, run:0};
    vecs[7]  = '{s:1, p:0, c:0, t:0, secs:1, run:1};
    vecs[8]  = '{s:0, p:0, c:0, t:1, secs:2, run:1};
    vecs[9]  = '{s:1, p:1, c:0, t:0, secs:2, run:0}; // pause beats start
    vecs[10] = '{s:1, p:0, c:0, t:1, secs:2, run:1}; // resume; strobe ignored
    vecs[11] = '{s:0, p:0, c:0, t:1, secs:3, run:1};
    vecs[12] = '{s:1, p:0, c:1, t:1, secs:0, run:0}; // clear wins
    vecs[13] = '{s:0, p:0, c:0, t:1, secs:0, run:0};

    // Reset values
    repeat (2) @(negedge clk);
    expect_both("reset", 0, 1'b0);
    compare_all();
`ifdef GAME_TIMER_SEG7_EN
    check_hex("reset_hex", 7'h40, 7'h40, 7'h40, 7'h40);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      expect_both($sformatf("vec%0d", i), vecs[i].secs, vecs[i].run);
      cycle(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].t);
    end

    // Reset and start, then five widely spaced strobes
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_both("start", 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      repeat (999) @(negedge clk);
      expect_both($sformatf("slow_strobe%0d", k), k, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Approach the minute: 1-minute instance expires at 01:00
    tick(53);
    expect_both("at_0058", 58, 1'b1);
    compare_all();
    expect_both("at_0059", 59, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("minute_carry", 1'b0, 60, 1'b1, 1'b0);
    expect_out("limit_hit", 1'b1, 60, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef GAME_TIMER_SEG7_EN
    check_hex("hex_lag", 7'h40, 7'h40, 7'h12, 7'h10);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_hex("hex_carry", 7'h40, 7'h79, 7'h40, 7'h40);
`endif
    tick(10);
    expect_out("run_past", 1'b0, 70, 1'b1, 1'b0);
    expect_out("limit_hold", 1'b1, 60, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Pause/strobe collision at 00:10
    expect_both("clear", 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_both("restart", 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tick(10);
    expect_both("pause_tick", 10, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    expect_both("resume", 10, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    expect_both("after_resume", 11, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset between edges at 07:42
    tick(451);
    expect_out("at_0742", 1'b0, 462, 1'b1, 1'b0);
    expect_out("lim_expired", 1'b1, 60, 1'b0, 1'b1);
    compare_all();
    #2;
    rst_n = 1'b0;
    #1;
    expect_both("async_reset", 0, 1'b0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    expect_both("post_reset_idle", 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Clear priority at 12:34
    expect_both("start2", 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tick(754);
    expect_out("at_1234", 1'b0, 754, 1'b1, 1'b0);
    expect_out("lim_expired2", 1'b1, 60, 1'b0, 1'b1);
    compare_all();
    expect_both("clear_prio", 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    expect_both("idle_after_clear", 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Game-clock stage for the sudoku design, directly downstream of the 50 MHz→1 Hz divider. It consumes the divider's one-cycle `clk_1Hz` strobe, keeps elapsed play time as a BCD `mm:ss` value, and exposes start/pause/clear control. At the configured limit (default 30:00) it freezes and flags `time_up`. Optionally it drives four 7-segment digits for the board display.

## Interface
- `LIMIT_MIN`, default 30: minute value at which the count stops. Legal range 1..99. Stop point is `LIMIT_MIN:00`.
- `SEG_ACTIVE_LOW`, default 1: segment polarity when 7-segment outputs are compiled in. 1 means a lit segment is driven 0.
- Clocking and reset are fixed: one clock, asynchronous active-low reset.
- `clk_50MHz`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `clk_1Hz`  in  1  one-cycle strobe from the divider, synchronous to `clk_50MHz`.
- `start`  in  1  level-sampled each cycle. Starts or resumes counting.
- `pause`  in  1  level-sampled each cycle. Holds the count.
- `clear`  in  1  level-sampled each cycle. Returns to 00:00 idle.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits.
- `running`  out  1  high while in RUN.
- `time_up`  out  1  high while in EXPIRED.
- `hex3`..`hex0`  out  7 each  segments {g,f,e,d,c,b,a}. `hex3` = `min_tens`. Present only with `GAME_TIMER_SEG7_EN`.

## Operation
States and transitions (single encoded state register):
- **IDLE**: count is 00:00. `start` → RUN.
- **RUN**: count advances on `clk_1Hz`. `pause` → PAUSED. Reaching the limit → EXPIRED.
- **PAUSED**: count held. `start` → RUN.
- **EXPIRED**: count held at `LIMIT_MIN:00`. Only `clear` leaves this state.

Control priority per cycle:
- `clear` wins from any state: → IDLE, count 00:00.
- Otherwise `pause`, then `start`, then `clk_1Hz`.

BCD increment, applied only in RUN with `clk_1Hz` high and no `pause`/`clear`:
- `sec_ones` 9→0 carries into `sec_tens`.
- `sec_tens` 5→0 carries into `min_ones`.
- `min_ones` 9→0 carries into `min_tens`.
- No binary counter is used internally. Digits never leave 0..9, and `sec_tens` never exceeds 0..5.

Limit and boundary rules:
- When the incremented value equals `LIMIT_MIN:00`, the state moves to EXPIRED on the same edge. The count never exceeds the limit and never wraps.
- `clk_1Hz` in IDLE, PAUSED or EXPIRED is ignored.
- `start` in RUN or EXPIRED has no effect.
- A strobe arriving in the same cycle as `start` from IDLE is not counted. The first count happens on the next strobe.
- `pause` and `clk_1Hz` in the same cycle: pause takes effect and the strobe is dropped.

## Timing
- Reset values: state IDLE; all BCD digits 0; `running`=0; `time_up`=0.
- With `GAME_TIMER_SEG7_EN`, reset value of `hex*` is the "0" glyph in the selected polarity (0x40 when active-low).
- Latency: BCD outputs change on the first rising edge after the cycle in which `clk_1Hz` is sampled high (1 cycle).
- `running` and `time_up` are registered and change on the same edge as the state.
- `hex*` outputs are registered from the BCD registers, so they lag the BCD outputs by one further cycle (2 cycles from strobe).
- Reset asserted mid-count clears everything immediately (asynchronous). Counting resumes only after deassertion and a `start`.

## Configuration
- `GAME_TIMER_SEG7_EN` defined: `hex3`..`hex0` ports and their decode registers exist.
- `GAME_TIMER_SEG7_EN` undefined: those ports and registers are absent. BCD, `running` and `time_up` behaviour is identical in both cases.

## Structure
- Shared package `sudoku_pkg` holds:
  - `timer_state_t` enum (IDLE, RUN, PAUSED, EXPIRED);
  - `bcd_t` (4-bit);
  - 7-segment glyph constants for 0..9 in active-high form.
- Sub-module `bcd_to_seg7`: combinational BCD→7-segment decode with a polarity parameter, instantiated four times under the macro.
- Non-BCD input to `bcd_to_seg7` decodes to blank.

## Test plan
- **Reset and start**: reset, `start` 1 cycle, 5 strobes 1000 cycles apart → 00:05, `running`=1, `time_up`=0.
- **Minute carry**: from 00:59, one strobe → 01:00 one cycle later. With the macro: `hex1` shows "0", `hex2` shows "1" two cycles after the strobe.
- **Limit**: `LIMIT_MIN`=1; from 00:58, 2 strobes → 01:00 with `time_up`=1, `running`=0. 10 more strobes and a `start` → still 01:00.
- **Pause/tick collision**: `pause` and `clk_1Hz` in the same cycle at 00:10 → 00:10 held. `start`, then one strobe → 00:11.
- **Clear priority**: `clear`, `start` and `clk_1Hz` together at 12:34 in RUN → 00:00, IDLE, `running`=0.
- **Async reset mid-count**: assert `rst_n`=0 between clock edges at 07:42 → all outputs 0 before the next edge.
